// File: rtl/race_controller_if.sv
// race_controller_if
// Bundles every signal between the drag-race sequencing controller and its
// surroundings (player buttons, finish sensors, timer instance, lamps and
// result displays). Clock and reset stay plain ports on the modules.
//
// Signal semantics:
//   go          single-cycle request pulse; only acted on in IDLE or FINISH.
//   restart     level; any cycle it is sampled high forces IDLE on that edge.
//   launch_pX   level; only meaningful while the countdown runs.
//   finish_pX   level or pulse; the first cycle seen during the race counts.
//   seconds /   running timer value, sampled on the same edge as finish_pX.
//   miliseconds
//   timer_start / timer_restart  drive the timer's start/restart inputs.
//   state, lights, green, pX_time, pX_done, false_start, winner  registered
//               status/result outputs; results hold until the next go.
// There is no back-pressure: every input is an event or level consumed on
// the edge it is sampled, and every output is valid the cycle it changes.
//
// Modports:
//   slave  - the controller (consumes inputs, drives status/results)
//   master - the environment (players, timer, testbench)
interface race_controller_if;
  logic        go;
  logic        restart;
  logic        launch_p1;
  logic        launch_p2;
  logic        finish_p1;
  logic        finish_p2;
  logic [11:0] seconds;
  logic [9:0]  miliseconds;
  logic        timer_start;
  logic        timer_restart;
  logic [1:0]  state;
  logic [2:0]  lights;
  logic        green;
  logic [21:0] p1_time;
  logic [21:0] p2_time;
  logic        p1_done;
  logic        p2_done;
  logic [1:0]  false_start;
  logic [1:0]  winner;

  modport slave (
    input  go, restart, launch_p1, launch_p2, finish_p1, finish_p2,
           seconds, miliseconds,
    output timer_start, timer_restart, state, lights, green,
           p1_time, p2_time, p1_done, p2_done, false_start, winner
  );

  modport master (
    output go, restart, launch_p1, launch_p2, finish_p1, finish_p2,
           seconds, miliseconds,
    input  timer_start, timer_restart, state, lights, green,
           p1_time, p2_time, p1_done, p2_done, false_start, winner
  );
endinterface

// File: rtl/race_controller.sv
// race_controller
// Sequencer for the drag-racing game: runs the three-stage red-light
// countdown, detects false starts, starts/restarts the shared timer,
// latches each player's finish time, decides the winner and holds results
// until the next race.
//
// Parameters:
//   LIGHT_MS  - cycles (ms) each red-light stage lasts (>= 2)
//   TIMEOUT_S - race abort threshold in timer seconds
// Ports:
//   clk1KHz   - 1 kHz clock, rising-edge active
//   reset_n   - asynchronous active-low reset
//   bus       - race_controller_if.slave (inputs, timer control, lamps,
//               results; state is exported as the FSM debug view)
module race_controller #(
  parameter int LIGHT_MS  = 1000,
  parameter int TIMEOUT_S = 30
) (
  input  logic              clk1KHz,
  input  logic              reset_n,
  race_controller_if.slave  bus
);

  localparam int CNT_W = $clog2(3 * LIGHT_MS);
  // Counter value during the last cycle of each light stage.
  localparam logic [CNT_W-1:0] STAGE1_END = CNT_W'(LIGHT_MS - 1);
  localparam logic [CNT_W-1:0] STAGE2_END = CNT_W'(2 * LIGHT_MS - 1);
  localparam logic [CNT_W-1:0] STAGE3_END = CNT_W'(3 * LIGHT_MS - 1);
  localparam logic [11:0]      TIMEOUT    = 12'(TIMEOUT_S);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COUNTDOWN = 2'd1,
    RACE      = 2'd2,
    FINISH    = 2'd3
  } state_t;

  state_t           st;
  logic [CNT_W-1:0] cnt;
  logic             timer_start_q;
  logic             timer_restart_q;
  logic [2:0]       lights_q;
  logic             green_q;
  logic [21:0]      p1_time_q;
  logic [21:0]      p2_time_q;
  logic             p1_done_q;
  logic             p2_done_q;
  logic [1:0]       false_start_q;
  logic [1:0]       winner_q;

  // First-time finishes this cycle and the resulting done flags.
  logic new1;
  logic new2;
  logic all_done;
  logic timed_out;

  always_comb begin
    new1      = bus.finish_p1 && !p1_done_q;
    new2      = bus.finish_p2 && !p2_done_q;
    all_done  = (p1_done_q || new1) && (p2_done_q || new2);
    timed_out = (bus.seconds >= TIMEOUT);
  end

  always_ff @(posedge clk1KHz or negedge reset_n) begin
    if (!reset_n) begin
      st              <= IDLE;
      cnt             <= '0;
      timer_start_q   <= 1'b0;
      timer_restart_q <= 1'b0;
      lights_q        <= 3'b000;
      green_q         <= 1'b0;
      p1_time_q       <= '0;
      p2_time_q       <= '0;
      p1_done_q       <= 1'b0;
      p2_done_q       <= 1'b0;
      false_start_q   <= 2'b00;
      winner_q        <= 2'b00;
    end else begin
      // timer_restart is a one-cycle strobe unless re-raised below.
      timer_restart_q <= 1'b0;
      if (bus.restart) begin
        // Abort wins over everything else; results stay visible.
        st              <= IDLE;
        timer_restart_q <= 1'b1;
        timer_start_q   <= 1'b0;
        lights_q        <= 3'b000;
        green_q         <= 1'b0;
      end else begin
        case (st)
          IDLE, FINISH: begin
            if (bus.go) begin
              st              <= COUNTDOWN;
              cnt             <= '0;
              timer_restart_q <= 1'b1;
              timer_start_q   <= 1'b0;
              green_q         <= 1'b0;
              lights_q        <= 3'b001;
              p1_time_q       <= '0;
              p2_time_q       <= '0;
              p1_done_q       <= 1'b0;
              p2_done_q       <= 1'b0;
              false_start_q   <= 2'b00;
              winner_q        <= 2'b00;
            end
          end
          COUNTDOWN: begin
            if (bus.launch_p1 || bus.launch_p2) begin
              // The other player wins; a simultaneous jump has no winner.
              st            <= FINISH;
              lights_q      <= 3'b000;
              green_q       <= 1'b0;
              false_start_q <= {bus.launch_p2, bus.launch_p1};
              winner_q      <= (bus.launch_p1 && bus.launch_p2) ? 2'b00 :
                               bus.launch_p1 ? 2'b10 : 2'b01;
            end else if (cnt == STAGE3_END) begin
              st            <= RACE;
              lights_q      <= 3'b000;
              green_q       <= 1'b1;
              timer_start_q <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
              if (cnt == STAGE1_END) lights_q <= 3'b011;
              else if (cnt == STAGE2_END) lights_q <= 3'b111;
            end
          end
          RACE: begin
            if (new1) begin
              p1_time_q <= {bus.seconds, bus.miliseconds};
              p1_done_q <= 1'b1;
            end
            if (new2) begin
              p2_time_q <= {bus.seconds, bus.miliseconds};
              p2_done_q <= 1'b1;
            end
            // winner is still 00 only while nobody has finished; the
            // {p2,p1} pattern yields 01, 10 or 11 for a same-cycle tie.
            if (winner_q == 2'b00 && (new1 || new2)) winner_q <= {new2, new1};
            if (all_done || timed_out) begin
              st            <= FINISH;
              timer_start_q <= 1'b0;
              green_q       <= 1'b0;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

  assign bus.state         = st;
  assign bus.timer_start   = timer_start_q;
  assign bus.timer_restart = timer_restart_q;
  assign bus.lights        = lights_q;
  assign bus.green         = green_q;
  assign bus.p1_time       = p1_time_q;
  assign bus.p2_time       = p2_time_q;
  assign bus.p1_done       = p1_done_q;
  assign bus.p2_done       = p2_done_q;
  assign bus.false_start   = false_start_q;
  assign bus.winner        = winner_q;

endmodule
